// File: rtl/awb_gain.sv
// ---------------------------------------------------------------------------
// awb_gain -- auto-white-balance gain computation and application.
//
// Purpose:
//   Captures per-channel frame means, derives the red and blue gains
//   K_R = G*64/R and K_B = G*64/B (unsigned Q2.6, saturated to 255) with a
//   shared sequential restoring divider, and applies the current gains to a
//   pixel stream with rounding and saturation.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   mean_valid_i   in   one-cycle strobe, r/g/b means valid
//   r_mean_i       in   [7:0] red frame mean
//   g_mean_i       in   [7:0] green frame mean
//   b_mean_i       in   [7:0] blue frame mean
//   valid_i        in   pixel valid
//   color_i        in   [1:0] pixel colour (0=R, 1=G, 2=B, 3=reserved)
//   value_i        in   [7:0] pixel value
//   last_i         in   last pixel of frame
//   ready_o        out  pixel accepted when high (only while idle)
//   valid_o        out  gained pixel valid
//   color_o        out  [1:0] gained pixel colour
//   value_o        out  [7:0] gained pixel value
//   last_o         out  gained pixel last flag
//   k_r_o          out  [7:0] current red gain, Q2.6
//   k_b_o          out  [7:0] current blue gain, Q2.6
// ---------------------------------------------------------------------------
module awb_gain (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mean_valid_i,
    input  logic [7:0] r_mean_i,
    input  logic [7:0] g_mean_i,
    input  logic [7:0] b_mean_i,
    input  logic       valid_i,
    input  logic [1:0] color_i,
    input  logic [7:0] value_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] color_o,
    output logic [7:0] value_o,
    output logic       last_o,
    output logic [7:0] k_r_o,
    output logic [7:0] k_b_o
);

    localparam logic [7:0] GAIN_ONE = 8'd64;
    localparam logic [3:0] CNT_LAST = 4'd13;   // 14 quotient bits: 0..13

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_R  = 2'd1,
        DIV_B  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Clamp a 14-bit quotient to the 8-bit gain range; a zero divisor always
    // yields full-scale gain regardless of the dividend.
    function automatic logic [7:0] sat_quotient(input logic [13:0] q,
                                                input logic        div_zero);
        logic [7:0] res;
        if (div_zero || (q[13:8] != 6'd0)) begin
            res = 8'd255;
        end else begin
            res = q[7:0];
        end
        return res;
    endfunction

    // (value * gain + 32) >> 6, clamped to 255. 17 bits hold the largest
    // product plus the rounding constant without overflow.
    function automatic logic [7:0] apply_gain(input logic [7:0] value,
                                              input logic [7:0] gain);
        logic [16:0] acc;
        logic [10:0] shifted;
        logic [7:0]  res;
        acc     = 17'(value) * 17'(gain) + 17'd32;
        shifted = acc[16:6];
        if (shifted[10:8] != 3'd0) begin
            res = 8'd255;
        end else begin
            res = shifted[7:0];
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  r_mean_q;
    logic [7:0]  g_mean_q;
    logic [7:0]  b_mean_q;
    logic [13:0] dvd_q;      // dividend, consumed MSB first
    logic [7:0]  rem_q;      // partial remainder, always < divisor
    logic [13:0] quo_q;      // quotient bits shifted in LSB side
    logic [7:0]  kr_res_q;   // red result parked until UPDATE
    logic        ready_q;
    logic [7:0]  k_r_q;
    logic [7:0]  k_b_q;

    logic        valid_q;
    logic [1:0]  color_q;
    logic [7:0]  value_q;
    logic        last_q;

    // -----------------------------------------------------------------------
    // Restoring divider step (one quotient bit per cycle)
    // -----------------------------------------------------------------------
    logic [7:0]  divisor_d;
    logic [8:0]  rem_sh_d;
    logic [8:0]  rem_step_d;
    logic        qbit_d;
    logic [13:0] quo_step_d;

    always_comb begin
        divisor_d  = (state_q == DIV_B) ? b_mean_q : r_mean_q;
        rem_sh_d   = {rem_q, dvd_q[13]};
        qbit_d     = (rem_sh_d >= {1'b0, divisor_d});
        rem_step_d = qbit_d ? (rem_sh_d - {1'b0, divisor_d}) : rem_sh_d;
        quo_step_d = {quo_q[12:0], qbit_d};
    end

    // -----------------------------------------------------------------------
    // Control FSM with divider datapath and gain registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            r_mean_q <= 8'd0;
            g_mean_q <= 8'd0;
            b_mean_q <= 8'd0;
            dvd_q    <= 14'd0;
            rem_q    <= 8'd0;
            quo_q    <= 14'd0;
            kr_res_q <= GAIN_ONE;
            ready_q  <= 1'b1;
            k_r_q    <= GAIN_ONE;
            k_b_q    <= GAIN_ONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mean_valid_i) begin
                        r_mean_q <= r_mean_i;
                        g_mean_q <= g_mean_i;
                        b_mean_q <= b_mean_i;
                        dvd_q    <= {g_mean_i, 6'd0};
                        rem_q    <= 8'd0;
                        quo_q    <= 14'd0;
                        cnt_q    <= 4'd0;
                        ready_q  <= 1'b0;
                        state_q  <= DIV_R;
                    end
                end

                DIV_R: begin
                    if (cnt_q == CNT_LAST) begin
                        // Park the red result and restart the divider on
                        // the same dividend for blue.
                        kr_res_q <= sat_quotient(quo_step_d, r_mean_q == 8'd0);
                        dvd_q    <= {g_mean_q, 6'd0};
                        rem_q    <= 8'd0;
                        quo_q    <= 14'd0;
                        cnt_q    <= 4'd0;
                        state_q  <= DIV_B;
                    end else begin
                        dvd_q <= dvd_q << 1;
                        rem_q <= rem_step_d[7:0];
                        quo_q <= quo_step_d;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                DIV_B: begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= rem_step_d[7:0];
                    quo_q <= quo_step_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= UPDATE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                UPDATE: begin
                    // Both gains change on the same edge.
                    k_r_q   <= kr_res_q;
                    k_b_q   <= sat_quotient(quo_q, b_mean_q == 8'd0);
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pixel path: one registered stage
    // -----------------------------------------------------------------------
    logic       pix_accept_d;
    logic [7:0] pix_value_d;

    always_comb begin
        pix_accept_d = valid_i & ready_q;
        case (color_i)
            2'd0:    pix_value_d = apply_gain(value_i, k_r_q);
            2'd2:    pix_value_d = apply_gain(value_i, k_b_q);
            default: pix_value_d = value_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            color_q <= 2'd0;
            value_q <= 8'd0;
        end else begin
            valid_q <= pix_accept_d;
            last_q  <= pix_accept_d & last_i;
            // Data holds its last value when nothing is accepted.
            if (pix_accept_d) begin
                color_q <= color_i;
                value_q <= pix_value_d;
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign color_o = color_q;
    assign value_o = value_q;
    assign last_o  = last_q;
    assign k_r_o   = k_r_q;
    assign k_b_o   = k_b_q;

endmodule

// File: tb/tb_awb_gain.sv
module tb_awb_gain;

    logic       clk;
    logic       rst_n;
    logic       mean_valid_i;
    logic [7:0] r_mean_i;
    logic [7:0] g_mean_i;
    logic [7:0] b_mean_i;
    logic       valid_i;
    logic [1:0] color_i;
    logic [7:0] value_i;
    logic       last_i;
    logic       ready_o;
    logic       valid_o;
    logic [1:0] color_o;
    logic [7:0] value_o;
    logic       last_o;
    logic [7:0] k_r_o;
    logic [7:0] k_b_o;

    int checks = 0;
    int errors = 0;

    awb_gain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mean_valid_i (mean_valid_i),
        .r_mean_i     (r_mean_i),
        .g_mean_i     (g_mean_i),
        .b_mean_i     (b_mean_i),
        .valid_i      (valid_i),
        .color_i      (color_i),
        .value_i      (value_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .color_o      (color_o),
        .value_o      (value_o),
        .last_o       (last_o),
        .k_r_o        (k_r_o),
        .k_b_o        (k_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] color;
        logic [7:0] value;
        logic       last;
        logic [7:0] exp_value;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture means, then check the busy window and the gain update timing:
    // cycle 29 after capture still shows old gains, cycle 30 shows the new ones.
    task automatic run_div(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [7:0] old_kr, input logic [7:0] old_kb,
                           input logic [7:0] exp_kr, input logic [7:0] exp_kb);
        r_mean_i     = r;
        g_mean_i     = g;
        b_mean_i     = b;
        mean_valid_i = 1'b1;
        step();
        mean_valid_i = 1'b0;
        check("busy_ready_low", ready_o, 0);
        repeat (28) step();
        check("update_ready_low", ready_o, 0);
        check("update_kr_old", k_r_o, old_kr);
        check("update_kb_old", k_b_o, old_kb);
        step();
        check("new_kr", k_r_o, exp_kr);
        check("new_kb", k_b_o, exp_kb);
        check("new_ready_high", ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Gains 128 / 255 are active while this table runs.
        tbl[0] = '{2'd0, 8'd100, 1'b0, 8'd200};
        tbl[1] = '{2'd2, 8'd100, 1'b0, 8'd255};
        tbl[2] = '{2'd1, 8'd77,  1'b0, 8'd77};
        tbl[3] = '{2'd3, 8'd9,   1'b0, 8'd9};
        tbl[4] = '{2'd0, 8'd1,   1'b0, 8'd2};
        tbl[5] = '{2'd0, 8'd127, 1'b0, 8'd254};
        tbl[6] = '{2'd0, 8'd128, 1'b0, 8'd255};
        tbl[7] = '{2'd2, 8'd1,   1'b0, 8'd4};
        tbl[8] = '{2'd2, 8'd0,   1'b0, 8'd0};
        tbl[9] = '{2'd1, 8'd255, 1'b1, 8'd255};

        rst_n        = 1'b0;
        mean_valid_i = 1'b0;
        r_mean_i     = 8'd0;
        g_mean_i     = 8'd0;
        b_mean_i     = 8'd0;
        valid_i      = 1'b0;
        color_i      = 2'd0;
        value_i      = 8'd0;
        last_i       = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_kr", k_r_o, 64);
        check("rst_kb", k_b_o, 64);
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_value", value_o, 0);
        check("rst_last", last_o, 0);
        check("rst_color", color_o, 0);
        rst_n = 1'b1;
        step();

        // Unity gain on red
        valid_i = 1'b1; color_i = 2'd0; value_i = 8'd37;
        step();
        valid_i = 1'b0;
        check("unity_valid", valid_o, 1);
        check("unity_value", value_o, 37);
        step();
        check("idle_valid_low", valid_o, 0);
        check("idle_value_hold", value_o, 37);

        // Gain computation: R=64 G=128 B=32 -> 128, 256 saturated to 255
        run_div(8'd64, 8'd128, 8'd32, 8'd64, 8'd64, 8'd128, 8'd255);

        // Pixel table, back to back
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            color_i = tbl[i].color;
            value_i = tbl[i].value;
            last_i  = tbl[i].last;
            step();
            check($sformatf("tbl%0d_valid", i), valid_o, 1);
            check($sformatf("tbl%0d_value", i), value_o, tbl[i].exp_value);
            check($sformatf("tbl%0d_color", i), color_o, tbl[i].color);
            check($sformatf("tbl%0d_last", i), last_o, tbl[i].last);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        step();
        check("post_tbl_valid", valid_o, 0);
        check("post_tbl_last", last_o, 0);
        check("post_tbl_value_hold", value_o, 255);

        // Zero means, with a red pixel on the capture edge using old gain 128
        r_mean_i = 8'd0; g_mean_i = 8'd0; b_mean_i = 8'd10;
        mean_valid_i = 1'b1;
        valid_i = 1'b1; color_i = 2'd0; value_i = 8'd100;
        step();
        mean_valid_i = 1'b0;
        valid_i = 1'b0;
        check("cap_pix_valid", valid_o, 1);
        check("cap_pix_value", value_o, 200);
        check("zero_busy", ready_o, 0);
        repeat (28) step();
        check("zero_kr_old", k_r_o, 128);
        step();
        check("zero_kr", k_r_o, 255);
        check("zero_kb", k_b_o, 0);
        check("zero_ready", ready_o, 1);

        // Busy window: R=100 G=50 B=200 -> 32, 16. Red pixel 10 at capture
        // uses old gain 255: (2550+32)>>6 = 40.
        r_mean_i = 8'd100; g_mean_i = 8'd50; b_mean_i = 8'd200;
        mean_valid_i = 1'b1;
        valid_i = 1'b1; color_i = 2'd0; value_i = 8'd10;
        step();
        cyc = 1;
        mean_valid_i = 1'b0;
        valid_i = 1'b0;
        check("busy_cap_value", value_o, 40);
        while (cyc < 5) begin step(); cyc++; end
        r_mean_i = 8'd50; g_mean_i = 8'd50; b_mean_i = 8'd50;
        mean_valid_i = 1'b1;
        valid_i = 1'b1; color_i = 2'd0; value_i = 8'd50;
        step(); cyc++;
        mean_valid_i = 1'b0;
        check("busy_drop0", valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            color_i = 2'(i);
            step(); cyc++;
            check($sformatf("busy_drop%0d", i + 1), valid_o, 0);
        end
        valid_i = 1'b0;
        check("busy_value_hold", value_o, 40);
        while (cyc < 29) begin step(); cyc++; end
        check("busy_ready_c29", ready_o, 0);
        step();
        check("busy_kr", k_r_o, 32);
        check("busy_kb", k_b_o, 16);
        check("busy_ready_c30", ready_o, 1);

        // Rounding with gains 32 / 16
        valid_i = 1'b1; color_i = 2'd0; value_i = 8'd3;
        step();
        check("round_r", value_o, 2);
        color_i = 2'd2; value_i = 8'd200;
        step();
        valid_i = 1'b0;
        check("round_b", value_o, 50);

        // Reset in the middle of a division
        r_mean_i = 8'd10; g_mean_i = 8'd200; b_mean_i = 8'd20;
        mean_valid_i = 1'b1;
        step();
        cyc = 1;
        mean_valid_i = 1'b0;
        while (cyc < 20) begin step(); cyc++; end
        rst_n = 1'b0;
        #1;
        check("midrst_kr", k_r_o, 64);
        check("midrst_kb", k_b_o, 64);
        check("midrst_ready", ready_o, 1);
        check("midrst_valid", valid_o, 0);
        check("midrst_value", value_o, 0);
        step();
        rst_n = 1'b1;
        repeat (15) step();
        check("aborted_kr", k_r_o, 64);
        check("aborted_kb", k_b_o, 64);
        check("aborted_ready", ready_o, 1);

        run_div(8'd100, 8'd100, 8'd100, 8'd64, 8'd64, 8'd64, 8'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/awb_gain.md
AWB_GAIN -- requirements
Module: awb_gain

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port mean_valid_i  in  1  one-cycle strobe; r/g/b means valid.
REQ-004 SHALL have ports r_mean_i, g_mean_i, b_mean_i  in  8 each  per-channel frame means from the Mean stage.
REQ-005 SHALL have port valid_i  in  1  pixel-stream valid.
REQ-006 SHALL have port color_i  in  2  pixel colour: 0=R, 1=G, 2=B, 3=reserved.
REQ-007 SHALL have port value_i  in  8  pixel value.
REQ-008 SHALL have port last_i  in  1  last pixel of frame.
REQ-009 SHALL have port ready_o  out  1  pixel stream accepted when high.
REQ-010 SHALL have ports valid_o  out  1,  color_o  out  2,  value_o  out  8,  last_o  out  1  gained pixel stream.
REQ-011 SHALL have ports k_r_o, k_b_o  out  8 each  current gains, unsigned Q2.6 (64 = 1.0).

Function
REQ-012 SHALL compute K_R = floor(g_mean*64 / r_mean) and K_B = floor(g_mean*64 / b_mean), each saturated to 255.
REQ-013 SHALL set a gain to 255 when its divisor mean is 0, including when g_mean is also 0.
REQ-014 SHALL capture all three means on a clock edge where mean_valid_i=1 and the FSM is in IDLE.
REQ-015 SHALL ignore mean_valid_i in any state other than IDLE.
REQ-016 SHALL use a sequential restoring divider with a 14-bit dividend, producing one quotient bit per cycle.
REQ-017 SHALL implement FSM states and transitions:
- IDLE -> DIV_R on capture.
- DIV_R runs 14 cycles -> DIV_B.
- DIV_B runs 14 cycles -> UPDATE.
- UPDATE runs 1 cycle -> IDLE.
REQ-018 SHALL write k_r_o and k_b_o together only in UPDATE, so the gains never update separately.
REQ-019 SHALL make the new gains visible, and ready_o high again, exactly 30 cycles after the capture edge.
REQ-020 SHALL hold ready_o=1 only in IDLE.
REQ-021 SHALL accept a pixel only when valid_i=1 and ready_o=1; pixels presented while ready_o=0 are dropped and produce no output.
REQ-022 SHALL process a pixel accepted on the capture edge itself using the old gains.
REQ-023 SHALL register the pixel outputs with 1-cycle latency: valid_o, color_o and last_o equal the accepted inputs, delayed one cycle.
REQ-024 SHALL compute value_o by colour:
- color 0: min(255, (value_i*k_r + 32) >> 6).
- color 2: min(255, (value_i*k_b + 32) >> 6).
- colours 1 and 3: value_i passed unchanged.
REQ-025 SHALL use a product width of at least 16 bits, with the rounding add performed before the shift.
REQ-026 SHALL drive valid_o=0 and last_o=0 on any cycle with no accepted pixel; value_o and color_o hold their last values.

Reset
REQ-027 SHALL, while rst_n=0, force:
- FSM to IDLE;
- k_r_o = k_b_o = 64;
- valid_o = last_o = 0, color_o = 0, value_o = 0;
- ready_o = 1 once the FSM is in IDLE.
REQ-028 SHALL abort any division in progress on reset, discard partial results, and leave the gains at 64.

Verification
REQ-029 SHALL cover reset: pulse rst_n low -> k_r_o=64, k_b_o=64, ready_o=1, valid_o=0, value_o=0.
REQ-030 SHALL cover gain computation: means R=64, G=128, B=32 -> after 30 cycles k_r_o=128, k_b_o=255 (256 saturated).
REQ-031 SHALL cover pixel gain with those gains:
- R pixel 100 -> value_o 200 one cycle later.
- B pixel 100 -> 255 (saturated).
- G pixel 77 -> 77.
- colour-3 pixel 9 -> 9.
- last_i on the final pixel -> last_o on the next cycle.
REQ-032 SHALL cover zero means: R=0, G=0, B=10 -> k_r_o=255, k_b_o=0.
REQ-033 SHALL cover the busy window: second mean_valid_i (R=G=B=50) at cycle +5 of a division is ignored; valid_i pulses during ready_o=0 give valid_o=0; the final gains reflect only the first capture.
REQ-034 SHALL cover reset mid-operation: rst_n low at cycle +20 of a division -> gains 64, FSM IDLE, ready_o=1; a fresh capture of R=G=B=100 then yields k_r_o = k_b_o = 64.
